// File: rtl/imm_seq_ctrl.sv
// imm_seq_ctrl: decode-stage immediate extender with a 2-entry skid buffer.
// The instruction word is decoded to an immediate-type code. The code and the
// extended immediate are registered together with the instruction.
// Optional feature: define IMM_ZEXT_LI_EN to zero-extend the LI immediate.

`ifndef IM0
`define IM0    3'd0
`define IM3    3'd1
`define IM4    3'd2
`define IM5    3'd3
`define IM8    3'd4
`define IM11   3'd5
`define IM_TO8 3'd6
`endif

module imm_seq_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [15:0] in_instr,
    output logic        in_ready,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_instr,
    output logic [2:0]  out_src_get,
    output logic [15:0] out_imm
);

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t      state_q, state_d;
    logic        in_ready_q, in_ready_d;
    logic [15:0] m_instr_q, m_instr_d, m_imm_q, m_imm_d;
    logic [2:0]  m_code_q, m_code_d;
    logic [15:0] s_instr_q, s_instr_d, s_imm_q, s_imm_d;
    logic [2:0]  s_code_q, s_code_d;

    logic [2:0]  dec_code;
    logic [15:0] dec_imm;
    logic        accept, take;

    // Team extender: widen Src according to the immediate-type code.
    function automatic logic [15:0] ext_imm(input logic [10:0] src, input logic [2:0] get);
        logic [15:0] r;
        r = '0;
        case (get)
            `IM3:    r = {13'd0, src[4:2]};
            `IM_TO8: r = 16'd8;
            `IM4:    r = {{12{src[3]}}, src[3:0]};
            `IM5:    r = {{11{src[4]}}, src[4:0]};
            `IM8:    r = {{8{src[7]}}, src[7:0]};
            `IM11:   r = {{5{src[10]}}, src[10:0]};
            default: r = '0;
        endcase
        return r;
    endfunction

    // Decode the opcode to an immediate-type code and extend the immediate.
    always_comb begin
        dec_code = `IM0;
        case (in_instr[15:11])
            5'b01000:                 dec_code = `IM4;
            5'b10011, 5'b11011:       dec_code = `IM5;
            5'b00010:                 dec_code = `IM11;
            5'b01001, 5'b00100, 5'b00101, 5'b01100,
            5'b01101, 5'b01110, 5'b10010, 5'b11010:
                                      dec_code = `IM8;
            5'b00110:                 dec_code = (in_instr[4:2] == 3'd0) ? `IM_TO8 : `IM3;
            default:                  dec_code = `IM0;
        endcase
        dec_imm = ext_imm(in_instr[10:0], dec_code);
`ifdef IMM_ZEXT_LI_EN
        if (in_instr[15:11] == 5'b01101) begin
            dec_imm = {8'h00, in_instr[7:0]};
        end
`endif
    end

    assign accept = in_valid & in_ready_q;
    assign take   = out_valid & out_ready;

    // Skid-buffer next state: flush wins over any accept or take.
    always_comb begin
        state_d   = state_q;
        m_instr_d = m_instr_q;
        m_imm_d   = m_imm_q;
        m_code_d  = m_code_q;
        s_instr_d = s_instr_q;
        s_imm_d   = s_imm_q;
        s_code_d  = s_code_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d   = ONE;
                        m_instr_d = in_instr;
                        m_imm_d   = dec_imm;
                        m_code_d  = dec_code;
                    end
                end
                ONE: begin
                    if (accept && !take) begin
                        state_d   = FULL;
                        s_instr_d = in_instr;
                        s_imm_d   = dec_imm;
                        s_code_d  = dec_code;
                    end else if (take && !accept) begin
                        state_d = EMPTY;
                    end else if (accept && take) begin
                        m_instr_d = in_instr;
                        m_imm_d   = dec_imm;
                        m_code_d  = dec_code;
                    end
                end
                FULL: begin
                    if (take) begin
                        state_d   = ONE;
                        m_instr_d = s_instr_q;
                        m_imm_d   = s_imm_q;
                        m_code_d  = s_code_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
        in_ready_d = (state_d != FULL);
    end

    // State and data registers; reset empties both entries and blocks input.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b0;
            m_instr_q  <= '0;
            m_imm_q    <= '0;
            m_code_q   <= `IM0;
            s_instr_q  <= '0;
            s_imm_q    <= '0;
            s_code_q   <= `IM0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            m_instr_q  <= m_instr_d;
            m_imm_q    <= m_imm_d;
            m_code_q   <= m_code_d;
            s_instr_q  <= s_instr_d;
            s_imm_q    <= s_imm_d;
            s_code_q   <= s_code_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = (state_q != EMPTY);
    assign out_instr   = m_instr_q;
    assign out_src_get = m_code_q;
    assign out_imm     = m_imm_q;

endmodule

// File: tb/tb_imm_seq_ctrl.sv
// tb_imm_seq_ctrl: directed bench for imm_seq_ctrl with hand-computed expectations.
module tb_imm_seq_ctrl;

    localparam logic [2:0] C_IM0  = 3'd0;
    localparam logic [2:0] C_IM3  = 3'd1;
    localparam logic [2:0] C_IM4  = 3'd2;
    localparam logic [2:0] C_IM5  = 3'd3;
    localparam logic [2:0] C_IM8  = 3'd4;
    localparam logic [2:0] C_IM11 = 3'd5;
    localparam logic [2:0] C_TO8  = 3'd6;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_instr = '0;
    logic        in_ready;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_instr;
    logic [2:0]  out_src_get;
    logic [15:0] out_imm;

    int unsigned passed = 0;
    int unsigned total  = 0;

    imm_seq_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_instr   (in_instr),
        .in_ready   (in_ready),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_src_get(out_src_get),
        .out_imm    (out_imm)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    initial begin
        logic [15:0] li_exp;
`ifdef IMM_ZEXT_LI_EN
        li_exp = 16'h0090;
`else
        li_exp = 16'hFF90;
`endif
        // Reset held
        tick(); tick();
        chk("rst_valid", {15'd0, out_valid}, 16'd0);
        chk("rst_ready", {15'd0, in_ready}, 16'd0);
        chk("rst_instr", out_instr, 16'h0000);
        chk("rst_code", {13'd0, out_src_get}, {13'd0, C_IM0});
        chk("rst_imm", out_imm, 16'h0000);

        // Release: in_ready rises only at the next edge
        rst = 1'b1;
        #1;
        chk("rel_ready_pre", {15'd0, in_ready}, 16'd0);
        tick();
        chk("rel_ready_post", {15'd0, in_ready}, 16'd1);

        // LW streaming, then SLL variants back to back
        out_ready = 1'b1; in_valid = 1'b1; in_instr = 16'h9813;
        tick();
        chk("lw_valid", {15'd0, out_valid}, 16'd1);
        chk("lw_instr", out_instr, 16'h9813);
        chk("lw_code", {13'd0, out_src_get}, {13'd0, C_IM5});
        chk("lw_imm", out_imm, 16'hFFF3);
        in_instr = 16'h3000;
        tick();
        chk("sll0_code", {13'd0, out_src_get}, {13'd0, C_TO8});
        chk("sll0_imm", out_imm, 16'h0008);
        in_instr = 16'h300C;
        tick();
        chk("sll3_code", {13'd0, out_src_get}, {13'd0, C_IM3});
        chk("sll3_imm", out_imm, 16'h0003);
        in_valid = 1'b0;
        tick();
        chk("drain_valid", {15'd0, out_valid}, 16'd0);

        // Fill to FULL with consumer stalled, then release
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 16'h17FF;
        tick();
        chk("b_code", {13'd0, out_src_get}, {13'd0, C_IM11});
        chk("b_imm", out_imm, 16'hFFFF);
        in_instr = 16'h4980;
        tick();
        chk("full_ready", {15'd0, in_ready}, 16'd0);
        chk("full_imm", out_imm, 16'hFFFF);
        in_instr = 16'h1234;
        tick();
        chk("hold_instr", out_instr, 16'h17FF);
        chk("hold_imm", out_imm, 16'hFFFF);
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        chk("skid_instr", out_instr, 16'h4980);
        chk("skid_code", {13'd0, out_src_get}, {13'd0, C_IM8});
        chk("skid_imm", out_imm, 16'hFF80);
        chk("skid_ready", {15'd0, in_ready}, 16'd1);
        tick();
        chk("skid_empty", {15'd0, out_valid}, 16'd0);

        // Flush while FULL with same-cycle accept and take
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 16'h17FF;
        tick();
        in_instr = 16'h4980;
        tick();
        chk("pre_flush_ready", {15'd0, in_ready}, 16'd0);
        flush = 1'b1; out_ready = 1'b1; in_instr = 16'h6C90;
        tick();
        chk("flush_valid", {15'd0, out_valid}, 16'd0);
        chk("flush_ready", {15'd0, in_ready}, 16'd1);
        flush = 1'b0; in_valid = 1'b0;
        tick();
        chk("flush_stays_empty", {15'd0, out_valid}, 16'd0);

        // LI, ADDIU3, and an IM0 opcode
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 16'h6C90;
        tick();
        chk("li_code", {13'd0, out_src_get}, {13'd0, C_IM8});
        chk("li_imm", out_imm, li_exp);
        in_instr = 16'h4007;
        tick();
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        chk("addiu3_code", {13'd0, out_src_get}, {13'd0, C_IM4});
        chk("addiu3_imm", out_imm, 16'h0007);
        in_valid = 1'b1; in_instr = 16'hE0FF;
        tick();
        chk("im0_instr", out_instr, 16'hE0FF);
        chk("im0_code", {13'd0, out_src_get}, {13'd0, C_IM0});
        chk("im0_imm", out_imm, 16'h0000);

        // Reset pulse while FULL
        out_ready = 1'b0; in_instr = 16'h17FF;
        tick();
        chk("pre_rst_ready", {15'd0, in_ready}, 16'd0);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        chk("async_rst_valid", {15'd0, out_valid}, 16'd0);
        chk("async_rst_ready", {15'd0, in_ready}, 16'd0);
        chk("async_rst_imm", out_imm, 16'h0000);
        #2;
        rst = 1'b1;
        tick();
        chk("post_rst_valid", {15'd0, out_valid}, 16'd0);
        chk("post_rst_ready", {15'd0, in_ready}, 16'd1);
        out_ready = 1'b1;
        tick();
        chk("no_stale_valid", {15'd0, out_valid}, 16'd0);
        in_valid = 1'b1; in_instr = 16'h9813;
        tick();
        chk("after_rst_instr", out_instr, 16'h9813);
        chk("after_rst_imm", out_imm, 16'hFFF3);
        in_valid = 1'b0;
        tick();
        chk("after_rst_drain", {15'd0, out_valid}, 16'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/imm_seq_ctrl.md
IMM_SEQ_CTRL -- requirements
Module: imm_seq_ctrl

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous active-low reset; asserted (0) clears all state immediately.
REQ-003 in_valid  input  1  decode-stage instruction word valid.
REQ-004 in_instr  input  16  instruction word from fetch stage.
REQ-005 in_ready  output  1  stage can accept in_instr this cycle; driven directly from a flop.
REQ-006 flush  input  1  synchronous kill of all buffered instructions (branch redirect).
REQ-007 out_valid  output  1  out_* fields hold a decoded instruction.
REQ-008 out_ready  input  1  execute stage consumes out_* this cycle.
REQ-009 out_instr  output  16  buffered instruction word.
REQ-010 out_src_get  output  3  immediate-type code: `IM0, `IM3, `IM4, `IM5, `IM8, `IM11 or `IM_TO8.
REQ-011 out_imm  output  16  extended immediate for out_instr.

Function
REQ-012 Decode in_instr[15:11] to a code SHALL follow this map:
  - 01000 (ADDIU3) -> `IM4
  - 10011, 11011 (LW, SW) -> `IM5
  - 00010 (B) -> `IM11
  - 01001, 00100, 00101, 01100, 01101, 01110, 10010, 11010 -> `IM8
  - 00110 (SLL/SRA) -> `IM3, or `IM_TO8 when in_instr[4:2]==0
  - all others -> `IM0
REQ-013 Extension SHALL use the team extender, with Src = in_instr[10:0] and SrcGet = the decoded code; the extender is combinational.
REQ-014 Decode and extension SHALL complete before capture; the captured immediate is registered with the instruction.
REQ-015 For `IM0, out_imm SHALL be 16'h0000; the stage never forwards a latched, undefined value.
REQ-016 Buffering SHALL be a 2-entry skid: main register M drives out_*, skid register S.
REQ-017 State machine SHALL be EMPTY, ONE (M valid), FULL (M and S valid).
REQ-018 Transitions (accept = in_valid&in_ready; take = out_valid&out_ready):
  - EMPTY: accept -> ONE (load M).
  - ONE: accept&!take -> FULL (load S); take&!accept -> EMPTY; accept&take -> ONE (reload M).
  - FULL: take -> ONE (S moves to M); in_ready=0, so no accept.
REQ-019 in_ready SHALL be 1 in EMPTY and ONE, and 0 in FULL.
REQ-020 out_valid SHALL be 1 in ONE and FULL.
REQ-021 Latency SHALL be one cycle: an instruction accepted at edge N is visible on out_* after edge N.
REQ-022 flush SHALL force EMPTY at the next edge, override any same-cycle accept or take, and discard the flushed instruction.
REQ-023 Order SHALL be preserved; no instruction is duplicated or dropped except by flush.
REQ-024 out_* SHALL stay stable while out_valid=1 and out_ready=0.

Reset
REQ-025 While rst=0: state EMPTY, out_valid=0, in_ready=0, out_instr=16'h0000, out_src_get=`IM0, out_imm=16'h0000, S cleared.
REQ-026 in_ready SHALL rise at the first clk edge after rst deasserts.
REQ-027 Reset mid-transfer SHALL drop all buffered entries without any out_valid pulse.

Configuration
REQ-028 With macro IMM_ZEXT_LI_EN defined, LI (opcode 01101) SHALL produce out_imm = {8'h00, instr[7:0]}, zero-extended.
REQ-029 Without IMM_ZEXT_LI_EN, LI SHALL be sign-extended per `IM8 like the other 8-bit opcodes.

Verification
REQ-030 Reset, then LW 16'h9813 with out_ready=1 -> next cycle out_valid=1, out_src_get=`IM5, out_imm=16'hFFF3.
REQ-031 SLL with [4:2]=0 (16'h3000) -> `IM_TO8, out_imm=16'h0008; with [4:2]=3 (16'h300C) -> `IM3, out_imm=16'h0003.
REQ-032 out_ready=0, push B 16'h17FF then ADDIU 16'h4980 -> FULL, in_ready=0, out_imm=16'hFFFF held; release -> 16'hFF80 next.
REQ-033 FULL, then flush=1 with out_ready=1 and in_valid=1 in the same cycle -> next cycle out_valid=0, in_ready=1, nothing consumed.
REQ-034 LI 16'h6C90: with IMM_ZEXT_LI_EN -> 16'h0090; without -> 16'hFF90.
REQ-035 rst=0 pulse while FULL -> out_valid=0 immediately, and no stale entries after release.
